// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for E. Owns HI/LO and times each op with a countdown counter.
// Optional macro MD_MADD_EN enables madd/maddu (ops 6/7), which accumulate into {hi,lo}.
module md_sched #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int W        = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         op_valid_e,
   input  logic [2:0]   op_code_e,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic         flush,
   input  logic         md_use_d,
   output logic         start,
   output logic         busy,
   output logic         stall_d,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);
   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [W-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic           pend_wr_q, pend_wr_d;
   logic           pend_acc_q, pend_acc_d;

   logic           acc, is_div, is_madd, is_timed, sgn;
   logic           a_neg, b_neg;
   logic [W-1:0]   ua, ub, uq, ur, q, r;
   logic [2*W-1:0] prod, res, acc_sum;

   // Result datapath: divide works on magnitudes so the most-negative / -1 case wraps cleanly.
   always_comb begin
      is_div = (op_code_e == 3'd2) || (op_code_e == 3'd3);
`ifdef MD_MADD_EN
      is_madd = op_code_e[2] & op_code_e[1];
`else
      is_madd = 1'b0;
`endif
      is_timed = ~op_code_e[2] | is_madd;
      sgn      = ~op_code_e[0];
      prod     = {{W{sgn & d1[W-1]}}, d1} * {{W{sgn & d2[W-1]}}, d2};
      a_neg    = sgn & d1[W-1];
      b_neg    = sgn & d2[W-1];
      ua       = a_neg ? -d1 : d1;
      ub       = b_neg ? -d2 : d2;
      uq       = (ub != '0) ? ua / ub : '0;
      ur       = (ub != '0) ? ua % ub : '0;
      q        = (a_neg ^ b_neg) ? -uq : uq;
      r        = a_neg ? -ur : ur;
      res      = is_div ? {r, q} : prod;
      acc_sum  = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         pend_hi_q  <= '0;
         pend_lo_q  <= '0;
         pend_wr_q  <= 1'b0;
         pend_acc_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         pend_hi_q  <= pend_hi_d;
         pend_lo_q  <= pend_lo_d;
         pend_wr_q  <= pend_wr_d;
         pend_acc_q <= pend_acc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      pend_hi_d  = pend_hi_q;
      pend_lo_d  = pend_lo_q;
      pend_wr_d  = pend_wr_q;
      pend_acc_d = pend_acc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               busy_d     = 1'b1;
               cnt_d      = is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
               pend_hi_d  = res[2*W-1:W];
               pend_lo_d  = res[W-1:0];
               pend_wr_d  = ~(is_div & (d2 == '0));
               pend_acc_d = is_madd;
            end else if (acc && op_code_e == 3'd4) begin
               hi_d = d1;
            end else if (acc && op_code_e == 3'd5) begin
               lo_d = d1;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // A divide by zero still times out but leaves HI/LO untouched.
               if (pend_wr_q) begin
                  if (pend_acc_q) begin
                     hi_d = acc_sum[2*W-1:W];
                     lo_d = acc_sum[W-1:0];
                  end else begin
                     hi_d = pend_hi_q;
                     lo_d = pend_lo_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc     = op_valid_e & ~flush & ~busy_q;
      start   = acc & is_timed;
      stall_d = md_use_d & (start | busy_q);
      busy    = busy_q;
      done    = done_q;
      hi      = hi_q;
      lo      = lo_q;
   end
endmodule
